// File: rtl/vfifo_traffic_gen.sv
// rtl/vfifo_traffic_gen.sv - AXI-stream pattern generator and checker for the DDR virtual FIFO
//
// Ports:
//   clk_tb, aresetn     : clock and synchronous active-low reset
//   start               : pulse, starts a sequence from IDLE or DONE
//   busy, done          : busy in WR/WR_WAIT/RD, done in DONE
//   m_axis_*            : counting pattern towards the VFIFO slave stream
//   s_axis_*            : VFIFO master stream being checked (tlast ignored)
//   run_count           : completed runs, wraps at 255
//   err_count           : data mismatches, saturates at 0xFFFF
//   timeout_flag        : sticky, a read phase ended on timeout
module vfifo_traffic_gen #(
  parameter int DATA_WIDTH   = 32,
  parameter int DEST_WIDTH   = 1,
  parameter int CHANNELS     = 2,
  parameter int BURST_WORDS  = 128,
  parameter int WRITE_DEPTH  = 4096,
  parameter int READ_DEPTH   = 4096,
  parameter int WAIT_CYCLES  = 0,
  parameter int READ_TIMEOUT = 4096,
  parameter int NR_OF_RUNS   = 2,
  parameter int TLAST_EN     = 1
) (
  input  logic                  clk_tb,
  input  logic                  aresetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic [DEST_WIDTH-1:0] m_axis_tdest,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  input  logic [DEST_WIDTH-1:0] s_axis_tdest,
  output logic [7:0]            run_count,
  output logic [15:0]           err_count,
  output logic                  timeout_flag
);

  localparam int CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  // tlast of the very first beat of a run (burst or run of length one)
  localparam logic FIRST_TLAST = ((TLAST_EN != 0) && (BURST_WORDS == 1)) || (WRITE_DEPTH == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_WR_WAIT,
    S_RD,
    S_DONE
  } state_t;

  state_t                state_q;
  logic [DATA_WIDTH-1:0] wr_seq_q  [CHANNELS];
  logic [DATA_WIDTH-1:0] exp_seq_q [CHANNELS];
  logic [CH_W-1:0]       tdest_q;
  logic [31:0]           beat_cnt_q;
  logic [31:0]           burst_cnt_q;
  logic [31:0]           wait_cnt_q;
  logic [31:0]           rd_cnt_q;
  logic [31:0]           idle_cnt_q;
  logic                  m_tvalid_q;
  logic                  m_tlast_q;
  logic [DATA_WIDTH-1:0] m_tdata_q;
  logic                  s_tready_q;
  logic [7:0]            run_count_q;
  logic [15:0]           err_count_q;
  logic                  timeout_q;

  // The checker does not use tlast; the VFIFO regroups beats anyway.
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;

  // ---------------------------------------------------------------------------
  // Write side: next word/tdest/tlast as they must look right after a beat,
  // so the registered outputs present the following word on the beat edge.
  // ---------------------------------------------------------------------------
  logic                  wr_beat;
  logic                  burst_end;
  logic                  final_beat;
  logic [CH_W-1:0]       tdest_d;
  logic [31:0]           burst_cnt_d;
  logic [31:0]           beat_cnt_d;
  logic [DATA_WIDTH-1:0] wr_seq_d [CHANNELS];
  logic [DATA_WIDTH-1:0] tdata_d;
  logic                  tlast_d;

  always_comb begin
    wr_beat     = (state_q == S_WR) && m_tvalid_q && m_axis_tready;
    burst_end   = (burst_cnt_q == 32'(BURST_WORDS - 1));
    final_beat  = (beat_cnt_q == 32'(WRITE_DEPTH - 1));
    burst_cnt_d = burst_end ? 32'd0 : burst_cnt_q + 32'd1;
    beat_cnt_d  = beat_cnt_q + 32'd1;

    tdest_d = tdest_q;
    if (burst_end) begin
      tdest_d = (32'(tdest_q) == 32'(CHANNELS - 1)) ? '0 : tdest_q + CH_W'(1);
    end

    for (int i = 0; i < CHANNELS; i++) begin
      wr_seq_d[i] = wr_seq_q[i];
    end
    wr_seq_d[tdest_q] = wr_seq_q[tdest_q] + DATA_WIDTH'(1);

    // After rotation the next word comes from the new channel's counter,
    // which already includes this beat's increment when channels match.
    tdata_d = wr_seq_d[tdest_d];
    tlast_d = ((TLAST_EN != 0) && (burst_cnt_d == 32'(BURST_WORDS - 1))) ||
              (beat_cnt_d == 32'(WRITE_DEPTH - 1));
  end

  // ---------------------------------------------------------------------------
  // Read side: compare against the per-channel expectation
  // ---------------------------------------------------------------------------
  logic            rd_beat;
  logic            ch_ok;
  logic            mismatch;
  logic [CH_W-1:0] ch_idx;
  logic [31:0]     rd_cnt_d;
  logic [31:0]     idle_cnt_d;
  logic [15:0]     err_count_d;
  logic            cnt_exit;
  logic            to_exit;
  logic            last_run;

  always_comb begin
    rd_beat    = (state_q == S_RD) && s_tready_q && s_axis_tvalid;
    ch_idx     = CH_W'(s_axis_tdest);
    ch_ok      = (32'(s_axis_tdest) < 32'(CHANNELS));
    mismatch   = !ch_ok || (s_axis_tdata != exp_seq_q[ch_idx]);
    rd_cnt_d   = rd_beat ? rd_cnt_q + 32'd1 : rd_cnt_q;
    idle_cnt_d = rd_beat ? 32'd0 : idle_cnt_q + 32'd1;

    err_count_d = err_count_q;
    if (rd_beat && mismatch && (err_count_q != 16'hFFFF)) begin
      err_count_d = err_count_q + 16'd1;
    end

    // Count exit has priority: a run that completes on the same cycle the
    // idle counter would expire is not a timeout.
    cnt_exit = (rd_cnt_d == 32'(READ_DEPTH));
    to_exit  = (idle_cnt_d == 32'(READ_TIMEOUT - 1));
    last_run = (NR_OF_RUNS != 0) && ((32'(run_count_q) + 32'd1) == 32'(NR_OF_RUNS));
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_tb) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      tdest_q     <= '0;
      beat_cnt_q  <= '0;
      burst_cnt_q <= '0;
      wait_cnt_q  <= '0;
      rd_cnt_q    <= '0;
      idle_cnt_q  <= '0;
      m_tvalid_q  <= 1'b0;
      m_tlast_q   <= 1'b0;
      m_tdata_q   <= '0;
      s_tready_q  <= 1'b0;
      run_count_q <= '0;
      err_count_q <= '0;
      timeout_q   <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        wr_seq_q[i]  <= '0;
        exp_seq_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q     <= S_WR;
            run_count_q <= '0;
            err_count_q <= '0;
            timeout_q   <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
              wr_seq_q[i]  <= '0;
              exp_seq_q[i] <= '0;
            end
            beat_cnt_q  <= '0;
            burst_cnt_q <= '0;
            tdest_q     <= '0;
            m_tdata_q   <= '0;
            m_tlast_q   <= FIRST_TLAST;
            m_tvalid_q  <= 1'b1;
          end
        end

        S_WR: begin
          if (wr_beat) begin
            for (int i = 0; i < CHANNELS; i++) begin
              wr_seq_q[i] <= wr_seq_d[i];
            end
            if (final_beat) begin
              m_tvalid_q  <= 1'b0;
              m_tlast_q   <= 1'b0;
              beat_cnt_q  <= '0;
              burst_cnt_q <= '0;
              tdest_q     <= '0;
              rd_cnt_q    <= '0;
              idle_cnt_q  <= '0;
              s_tready_q  <= 1'b1;
              state_q     <= S_RD;
            end else begin
              beat_cnt_q  <= beat_cnt_d;
              burst_cnt_q <= burst_cnt_d;
              tdest_q     <= tdest_d;
              m_tdata_q   <= tdata_d;
              m_tlast_q   <= tlast_d;
              if (burst_end && (WAIT_CYCLES > 0)) begin
                m_tvalid_q <= 1'b0;
                wait_cnt_q <= '0;
                state_q    <= S_WR_WAIT;
              end
            end
          end
        end

        S_WR_WAIT: begin
          // tvalid went low on the burst-end edge; raise it after
          // WAIT_CYCLES full cycles with the next word already staged.
          if (wait_cnt_q == 32'(WAIT_CYCLES - 1)) begin
            m_tvalid_q <= 1'b1;
            state_q    <= S_WR;
          end else begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end

        S_RD: begin
          rd_cnt_q    <= rd_cnt_d;
          idle_cnt_q  <= idle_cnt_d;
          err_count_q <= err_count_d;
          // Resync to the received word so one bad beat is not a cascade.
          if (rd_beat && ch_ok) begin
            exp_seq_q[ch_idx] <= s_axis_tdata + DATA_WIDTH'(1);
          end
          if (cnt_exit || to_exit) begin
            s_tready_q  <= 1'b0;
            run_count_q <= run_count_q + 8'd1;
            if (!cnt_exit) begin
              timeout_q <= 1'b1;
            end
            if (last_run) begin
              state_q <= S_DONE;
            end else begin
              state_q     <= S_WR;
              m_tvalid_q  <= 1'b1;
              m_tdata_q   <= wr_seq_q[0];
              m_tlast_q   <= FIRST_TLAST;
              beat_cnt_q  <= '0;
              burst_cnt_q <= '0;
              tdest_q     <= '0;
            end
          end
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy          = (state_q == S_WR) || (state_q == S_WR_WAIT) || (state_q == S_RD);
  assign done          = (state_q == S_DONE);
  assign m_axis_tvalid = m_tvalid_q;
  assign m_axis_tdata  = m_tdata_q;
  assign m_axis_tlast  = m_tlast_q;
  assign m_axis_tdest  = DEST_WIDTH'(tdest_q);
  assign s_axis_tready = s_tready_q;
  assign run_count     = run_count_q;
  assign err_count     = err_count_q;
  assign timeout_flag  = timeout_q;

endmodule
